// File: rtl/repetition_ecc_pipe.sv
// repetition_ecc_pipe: 2-stage repetition-code encoder / majority-vote decoder
// with scrub re-encode, per-beat status and saturating error statistics.
module repetition_ecc_pipe #(
  parameter int DATA_WIDTH        = 8,
  parameter int REPETITION_FACTOR = 3,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    mode,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH-1:0]                   data_in,
  input  logic [DATA_WIDTH*REPETITION_FACTOR-1:0] codeword_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH*REPETITION_FACTOR-1:0] codeword_out,
  output logic [DATA_WIDTH-1:0]                   data_out,
  output logic                                    error_detected,
  output logic                                    error_corrected,
  output logic                                    uncorrectable,
  output logic [$clog2(DATA_WIDTH+1)-1:0]         group_err_count,
  input  logic                                    clr_stats,
  output logic [CNT_WIDTH-1:0]                    corrected_count,
  output logic [CNT_WIDTH-1:0]                    uncorrectable_count
);
  localparam int DW = DATA_WIDTH;
  localparam int R  = REPETITION_FACTOR;
  localparam int GW = $clog2(DATA_WIDTH+1);
  localparam int OW = $clog2(REPETITION_FACTOR+1);

  typedef struct packed {
    logic [DW*R-1:0] cw;
    logic [DW-1:0]   d;
    logic            det;
    logic            cor;
    logic            unc;
    logic [GW-1:0]   gec;
  } beat_t;

  beat_t                s1_d, s1_q, s2_q;
  logic                 s1_v_q, s2_v_q, s1_adv, s2_adv, hs, tie;
  logic [DW-1:0]        dec, src;
  logic [OW-1:0]        ones;
  logic [GW-1:0]        gcnt;
  logic [CNT_WIDTH-1:0] corr_d, corr_q, unc_d, unc_q;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  assign hs       = s2_v_q && out_ready;

  // Even R: a group with exactly half ones is a tie, resolved to 0 and flagged.
  always_comb begin
    dec  = '0;
    tie  = 1'b0;
    gcnt = '0;
    ones = '0;
    s1_d = '0;
    for (int i = 0; i < DW; i++) begin
      ones = '0;
      for (int j = 0; j < R; j++) ones = ones + OW'(codeword_in[i*R+j]);
      dec[i] = 2 * int'(ones) > R;
      tie    = tie || (2 * int'(ones) == R);
      gcnt   = gcnt + GW'(ones != '0 && int'(ones) != R);
    end
    src = mode ? dec : data_in;
    for (int i = 0; i < DW; i++) s1_d.cw[i*R +: R] = {R{src[i]}};
    s1_d.d   = src;
    s1_d.gec = mode ? gcnt : '0;
    s1_d.det = mode && gcnt != '0;
    s1_d.unc = mode && tie;
    s1_d.cor = mode && gcnt != '0 && !tie;
  end

  assign corr_d = clr_stats ? '0 : (hs && s2_q.cor && !(&corr_q)) ? corr_q + 1'b1 : corr_q;
  assign unc_d  = clr_stats ? '0 : (hs && s2_q.unc && !(&unc_q)) ? unc_q + 1'b1 : unc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      s2_q   <= '0;
      corr_q <= '0;
      unc_q  <= '0;
    end else begin
      if (s1_adv) s1_v_q <= in_valid;
      if (s1_adv && in_valid) s1_q <= s1_d;
      if (s2_adv) s2_v_q <= s1_v_q;
      if (s2_adv && s1_v_q) s2_q <= s1_q;
      corr_q <= corr_d;
      unc_q  <= unc_d;
    end
  end

  assign out_valid           = s2_v_q;
  assign codeword_out        = s2_q.cw;
  assign data_out            = s2_q.d;
  assign error_detected      = s2_q.det;
  assign error_corrected     = s2_q.cor;
  assign uncorrectable       = s2_q.unc;
  assign group_err_count     = s2_q.gec;
  assign corrected_count     = corr_q;
  assign uncorrectable_count = unc_q;
endmodule
